// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter. Pops one byte at a
// time, pulses uart_trig for one cycle while the transmitter is idle, then holds
// off for a guard gap after busy falls so the line idles for a full bit time.
module uart_tx_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned GAP_CYCLES = 434
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_count,
  output logic          wr_drop,
  input  logic          uart_tx_busy,
  output logic          uart_trig,
  output logic [7:0]    uart_tx_data
);

  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GapLast   = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StTrig, StAck, StSend, StGap} state_e;

  state_e        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [GW-1:0] gap_q;
  logic          wr_accept;
  logic          pop;

  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;

  // Full is the registered flag, so a pop in the same cycle does not make room.
  assign wr_accept = wr_en && !fifo_full;
  assign pop       = (state_q == StIdle) && !fifo_empty && !uart_tx_busy;

  // Byte storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (rstn && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, occupancy count and the overflow pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_en && fifo_full;
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!wr_accept && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Pacing FSM: pop + trigger, wait for busy to rise then fall, then guard gap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      uart_trig    <= 1'b0;
      uart_tx_data <= 8'h00;
      gap_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            uart_tx_data <= mem_q[rd_ptr_q];
            uart_trig    <= 1'b1;
            state_q      <= StTrig;
          end
        end
        StTrig: begin
          uart_trig <= 1'b0;
          state_q   <= StAck;
        end
        StAck: begin
          // No timeout: the transmitter is trusted to eventually go busy.
          if (uart_tx_busy) begin
            state_q <= StSend;
          end
        end
        StSend: begin
          if (!uart_tx_busy) begin
            gap_q   <= '0;
            state_q <= StGap;
          end
        end
        StGap: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GapLast) begin
            state_q <= StIdle;
          end
        end
        default: begin
          uart_trig <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: randomized writes, a transmitter
// model driving busy, and a timestamp-based reference of the pacing rules.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int          GAP   = 434;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          wr_drop;
  logic          uart_tx_busy;
  logic          uart_trig;
  logic [7:0]    uart_tx_data;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .wr_drop      (wr_drop),
    .uart_tx_busy (uart_tx_busy),
    .uart_trig    (uart_trig),
    .uart_tx_data (uart_tx_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0] m_q[$];
  int         cyc = 0;
  bit         chk_en = 1'b0;
  bit         m_pending = 1'b0;
  bit         m_ack = 1'b0;
  int         m_trig_cyc = 0;
  int         m_fall_cyc = -1000000;
  logic [7:0] exp_data = 8'h00;
  bit         exp_trig = 1'b0;
  bit         exp_drop = 1'b0;

  // Transmitter model controls.
  bit force_busy = 1'b0;
  int tx_len_cfg = 0;
  int tx_rem = 0;
  bit prev_trig = 1'b0;
  int trig_seen = 0;

  // Mid-cycle: check outputs, advance the transmitter, then predict next cycle.
  initial begin
    uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("fifo_count", fifo_count, m_q.size());
        check("fifo_empty", fifo_empty, m_q.size() == 0);
        check("fifo_full", fifo_full, m_q.size() == DEPTH);
        check("wr_drop", wr_drop, exp_drop);
        check("uart_trig", uart_trig, exp_trig);
        check("uart_tx_data", uart_tx_data, exp_data);
      end
      if (uart_trig === 1'b1) trig_seen++;

      if (prev_trig) tx_rem = (tx_len_cfg != 0) ? tx_len_cfg : int'($urandom_range(20, 60));
      else if (tx_rem > 0) tx_rem--;
      uart_tx_busy = force_busy || (tx_rem > 0);
      prev_trig = (uart_trig === 1'b1);

      if (rstn !== 1'b1) begin
        m_q.delete();
        m_pending  = 1'b0;
        m_ack      = 1'b0;
        m_fall_cyc = -1000000;
        exp_trig   = 1'b0;
        exp_drop   = 1'b0;
        exp_data   = 8'h00;
        chk_en     = 1'b1;
      end else begin
        bit do_pop;
        do_pop = 1'b0;
        // A frame is done once busy has been seen high after the trigger, then low.
        if (m_pending && cyc > m_trig_cyc) begin
          if (!m_ack) begin
            if (uart_tx_busy) m_ack = 1'b1;
          end else if (!uart_tx_busy) begin
            m_fall_cyc = cyc;
            m_pending  = 1'b0;
          end
        end
        exp_drop = (wr_en === 1'b1) && (m_q.size() == DEPTH);
        if (!m_pending && cyc >= m_fall_cyc + GAP + 1 && m_q.size() > 0 && !uart_tx_busy) begin
          do_pop     = 1'b1;
          exp_data   = m_q.pop_front();
          m_pending  = 1'b1;
          m_ack      = 1'b0;
          m_trig_cyc = cyc + 1;
        end
        exp_trig = do_pop;
        if (wr_en === 1'b1 && !exp_drop) m_q.push_back(wr_data);
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(m_q.size() == 0 && !m_pending && cyc >= m_fall_cyc + GAP + 2) && n < 30000) begin
      step();
      n++;
    end
    check("drain_timeout", n < 30000, 1);
  endtask

  initial begin
    int t0;
    int n;
    rstn    = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      wr_data = 8'($urandom);
    end
    rstn  = 1'b1;
    wr_en = 1'b0;
    check("rst_count", fifo_count, 0);
    check("rst_trig", uart_trig, 0);
    check("rst_data", uart_tx_data, 0);

    // Single byte with a long frame.
    tx_len_cfg = 3900;
    t0 = cyc;
    write_byte(8'hA5);
    n = 0;
    while (uart_trig !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("single_latency", cyc - t0, 2);
    check("single_data", uart_tx_data, 8'hA5);
    step();
    check("single_empty", fifo_empty, 1);
    drain();
    tx_len_cfg = 0;

    // Burst of four consecutive writes.
    for (int i = 1; i <= 4; i++) write_byte(8'(i));
    drain();

    // Overflow while the transmitter is held busy.
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) write_byte(8'($urandom));
    check("ovf_full", fifo_full, 1);
    check("ovf_count", fifo_count, 16);
    check("ovf_drop", wr_drop, 1);
    force_busy = 1'b0;
    drain();

    // Simultaneous write and pop at count 1.
    force_busy = 1'b1;
    write_byte(8'($urandom));
    force_busy = 1'b0;
    write_byte(8'($urandom));
    check("simul_count", fifo_count, 1);
    check("simul_trig", uart_trig, 1);
    drain();

    // Simultaneous write and pop while full: the write is dropped.
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'($urandom));
    force_busy = 1'b0;
    write_byte(8'($urandom));
    check("full_simul_drop", wr_drop, 1);
    check("full_simul_count", fifo_count, 15);
    drain();

    // Reset in the middle of a frame with five bytes still queued.
    for (int i = 0; i < 6; i++) write_byte(8'($urandom));
    n = 0;
    while (!(m_pending && m_ack) && n < 2000) begin
      step();
      n++;
    end
    check("send_reached", n < 2000, 1);
    step();
    step();
    check("pre_rst_count", fifo_count, 5);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", fifo_empty, 1);
    t0 = trig_seen;
    for (int i = 0; i < 600; i++) step();
    check("no_trig_after_rst", trig_seen - t0, 0);
    write_byte(8'h3C);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
